// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 interrupt controller: per-line edge capture, mask, fixed priority, CAUSE, EXL guard.
// Optional build macro CP0_VECTORED_IRQ_EN: interrupt target is EHBR + (id << VEC_SHIFT).
module cp0_irq_ctrl #(
  parameter int          IRQ_NUM    = 4,
  parameter logic [31:0] EHBR_RESET = 32'h20,
  parameter int          VEC_SHIFT  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic               irout
);

`ifdef CP0_VECTORED_IRQ_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_ERET  = 2'd2;

  logic               ie, exl;
  logic [31:0]        ehbr, epc;
  logic [3:0]         cause_id;
  logic [IRQ_NUM-1:0] pending, mask, prev;
  logic [31:0]        scratch [5:31];

  logic [IRQ_NUM-1:0] masked, edge_set, pending_nxt;
  logic [3:0]         id;
  logic               ir, eret, store;
  logic [31:0]        vec_off;

  assign masked   = pending & mask;
  assign edge_set = ir_in & ~prev;
  assign ir       = ir_en & ie & ~exl & (|masked);
  assign eret     = (oper == OP_ERET) & ~ir;
  assign store    = (oper == OP_STORE) & ~ir;
  assign irout    = ~exl;

  // Fixed priority: lowest index wins, so scan downward and let the last hit stand.
  always_comb begin
    id = 4'd0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (masked[i]) id = i[3:0];
    end
  end

  assign vec_off = VECTORED ? ({28'd0, id} << VEC_SHIFT) : 32'd0;

  always_comb begin
    jump_en   = 1'b0;
    jump_addr = ehbr;
    if (ir) begin
      jump_en   = 1'b1;
      jump_addr = ehbr + vec_off;
    end else if (eret) begin
      jump_en   = 1'b1;
      jump_addr = epc;
    end
  end

  // A fresh edge beats both the W1C clear and the entry clear on the same line.
  always_comb begin
    pending_nxt = pending;
    if (store && addr_w == 5'd3) pending_nxt = pending_nxt & ~data_w[IRQ_NUM-1:0];
    if (ir) pending_nxt[id] = 1'b0;
    pending_nxt = pending_nxt | edge_set;
  end

  always_comb begin
    data_r = 32'd0;
    case (addr_r)
      5'd0: data_r[1:0] = {exl, ie};
      5'd1: data_r = ehbr;
      5'd2: data_r = epc;
      5'd3: begin
        data_r[IRQ_NUM-1:0] = pending;
        data_r[19:16]       = cause_id;
      end
      5'd4: data_r[IRQ_NUM-1:0] = mask;
      default: data_r = scratch[addr_r];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie       <= 1'b1;
      exl      <= 1'b0;
      ehbr     <= EHBR_RESET;
      epc      <= 32'd0;
      cause_id <= 4'd0;
      pending  <= '0;
      mask     <= '1;
      prev     <= '0;
      for (int i = 5; i < 32; i++) scratch[i] <= 32'd0;
    end else begin
      prev    <= ir_in;
      pending <= pending_nxt;
      if (ir) begin
        epc      <= ret_addr;
        exl      <= 1'b1;
        cause_id <= id;
      end else begin
        if (store) begin
          case (addr_w)
            5'd0: {exl, ie} <= data_w[1:0];
            5'd1: ehbr <= data_w;
            5'd2: epc <= data_w;
            5'd3: ;
            5'd4: mask <= data_w[IRQ_NUM-1:0];
            default: scratch[addr_w] <= data_w;
          endcase
        end
        if (eret) exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed-vector bench for cp0_irq_ctrl (IRQ_NUM=4, EHBR_RESET=0x20, VEC_SHIFT=3).
module tb_cp0_irq_ctrl;

`ifdef CP0_VECTORED_IRQ_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  oper = 2'd0;
  logic [4:0]  addr_r = 5'd0, addr_w = 5'd0;
  logic [31:0] data_w = 32'd0, ret_addr = 32'd0;
  logic        ir_en = 1'b0;
  logic [3:0]  ir_in = 4'd0;
  logic [31:0] data_r, jump_addr;
  logic        jump_en, irout;

  int checks = 0;
  int failures = 0;

  cp0_irq_ctrl #(.IRQ_NUM(4), .EHBR_RESET(32'h20), .VEC_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .irout(irout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  ar;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic        ien;
    logic [3:0]  irq;
    logic [31:0] ra;
    logic        jen;
    logic [31:0] ja;
    logic        iro;
    logic [31:0] dr;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  function automatic logic [31:0] ev(input int id);
    return 32'h20 + (VECTORED ? 32'(id * 8) : 32'd0);
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] ar, input logic [4:0] aw,
                              input logic [31:0] dw, input logic ien, input logic [3:0] irq,
                              input logic [31:0] ra, input logic jen, input logic [31:0] ja,
                              input logic iro, input logic [31:0] dr);
    vec_t v;
    v.op = op; v.ar = ar; v.aw = aw; v.dw = dw; v.ien = ien; v.irq = irq; v.ra = ra;
    v.jen = jen; v.ja = ja; v.iro = iro; v.dr = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    // op ar aw dw ien irq ra | jen ja iro dr
    tbl[0]  = mk(0, 0, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  1, 32'h1);
    tbl[1]  = mk(0, 1, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  1, 32'h20);
    tbl[2]  = mk(0, 4, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  1, 32'hF);
    tbl[3]  = mk(0, 3, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  1, 32'h0);
    tbl[4]  = mk(0, 3, 0, 0, 1, 4'b0100, 32'h100, 0, 32'h20,  1, 32'h0);
    tbl[5]  = mk(0, 3, 0, 0, 1, 4'b0000, 32'h100, 1, ev(2),   1, 32'h4);
    tbl[6]  = mk(0, 2, 0, 0, 1, 4'b0000, 32'h100, 0, 32'h20,  0, 32'h100);
    tbl[7]  = mk(0, 3, 0, 0, 1, 4'b0000, 32'h100, 0, 32'h20,  0, 32'h20000);
    tbl[8]  = mk(2, 0, 0, 0, 1, 4'b0000, 32'h100, 1, 32'h100, 0, 32'h3);
    tbl[9]  = mk(0, 0, 0, 0, 1, 4'b0000, 32'h100, 0, 32'h20,  1, 32'h1);
    tbl[10] = mk(0, 3, 0, 0, 1, 4'b1010, 32'h200, 0, 32'h20,  1, 32'h20000);
    tbl[11] = mk(0, 3, 0, 0, 1, 4'b1010, 32'h200, 1, ev(1),   1, 32'h2000A);
    tbl[12] = mk(0, 3, 0, 0, 1, 4'b1010, 32'h200, 0, 32'h20,  0, 32'h10008);
    tbl[13] = mk(2, 2, 0, 0, 1, 4'b1010, 32'h200, 1, 32'h200, 0, 32'h200);
    tbl[14] = mk(0, 3, 0, 0, 1, 4'b1010, 32'h300, 1, ev(3),   1, 32'h10008);
    tbl[15] = mk(0, 3, 0, 0, 1, 4'b0000, 32'h300, 0, 32'h20,  0, 32'h30000);
    tbl[16] = mk(2, 2, 0, 0, 1, 4'b0000, 32'h300, 1, 32'h300, 0, 32'h300);
    tbl[17] = mk(1, 4, 4, 32'hE, 1, 4'b0000, 0,   0, 32'h20,  1, 32'hF);
    tbl[18] = mk(0, 4, 0, 0, 1, 4'b0001, 0,       0, 32'h20,  1, 32'hE);
    tbl[19] = mk(0, 3, 0, 0, 1, 4'b0000, 0,       0, 32'h20,  1, 32'h30001);
    tbl[20] = mk(1, 3, 4, 32'hF, 1, 4'b0000, 0,   0, 32'h20,  1, 32'h30001);
    tbl[21] = mk(0, 4, 0, 0, 1, 4'b0000, 32'h400, 1, ev(0),   1, 32'hF);
    tbl[22] = mk(0, 3, 0, 0, 1, 4'b0100, 32'h400, 0, 32'h20,  0, 32'h0);
    tbl[23] = mk(0, 3, 0, 0, 1, 4'b0100, 32'h400, 0, 32'h20,  0, 32'h4);
    tbl[24] = mk(2, 3, 0, 0, 1, 4'b0100, 32'h400, 1, 32'h400, 0, 32'h4);
    tbl[25] = mk(0, 3, 0, 0, 1, 4'b0100, 32'h500, 1, ev(2),   1, 32'h4);
    tbl[26] = mk(2, 2, 0, 0, 1, 4'b0000, 32'h500, 1, 32'h500, 0, 32'h500);
    tbl[27] = mk(1, 3, 3, 32'h4, 0, 4'b0100, 0,   0, 32'h20,  1, 32'h20000);
    tbl[28] = mk(0, 3, 0, 0, 0, 4'b0100, 0,       0, 32'h20,  1, 32'h20004);
    tbl[29] = mk(1, 3, 3, 32'h4, 0, 4'b0100, 0,   0, 32'h20,  1, 32'h20004);
    tbl[30] = mk(0, 3, 0, 0, 0, 4'b0100, 0,       0, 32'h20,  1, 32'h20000);
    tbl[31] = mk(0, 2, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  1, 32'h500);
    tbl[32] = mk(0, 2, 0, 0, 0, 4'b0001, 0,       0, 32'h20,  1, 32'h500);
    tbl[33] = mk(1, 2, 2, 32'h400, 1, 4'b0001, 32'h200, 1, ev(0), 1, 32'h500);
    tbl[34] = mk(0, 2, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  0, 32'h200);
    tbl[35] = mk(1, 9, 9, 32'hDEADBEEF, 0, 4'b0000, 0, 0, 32'h20, 0, 32'h0);
    tbl[36] = mk(0, 9, 0, 0, 0, 4'b0000, 0,       0, 32'h20,  0, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      oper = tbl[k].op; addr_r = tbl[k].ar; addr_w = tbl[k].aw; data_w = tbl[k].dw;
      ir_en = tbl[k].ien; ir_in = tbl[k].irq; ret_addr = tbl[k].ra;
      @(negedge clk);
      chk($sformatf("v%0d jump_en", k), {31'd0, jump_en}, {31'd0, tbl[k].jen});
      if (tbl[k].jen) chk($sformatf("v%0d jump_addr", k), jump_addr, tbl[k].ja);
      chk($sformatf("v%0d irout", k), {31'd0, irout}, {31'd0, tbl[k].iro});
      chk($sformatf("v%0d data_r", k), data_r, tbl[k].dr);
    end

    // Async reset mid-handler: values must return with no clock edge in between.
    oper = 2'd0; ir_en = 1'b0; ir_in = 4'd0; addr_r = 5'd2;
    #1 rst_n = 1'b0;
    #1;
    chk("rst irout", {31'd0, irout}, 32'd1);
    chk("rst epc", data_r, 32'd0);
    addr_r = 5'd9; #1;
    chk("rst scratch", data_r, 32'd0);
    addr_r = 5'd0; #1;
    chk("rst status", data_r, 32'd1);
    addr_r = 5'd4; #1;
    chk("rst mask", data_r, 32'hF);
    chk("rst jump_en", {31'd0, jump_en}, 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // ERET with EXL already clear still jumps to EPC (0 after reset).
    @(posedge clk);
    #1 oper = 2'd2; addr_r = 5'd0;
    @(negedge clk);
    chk("eret exl0 jump_en", {31'd0, jump_en}, 32'd1);
    chk("eret exl0 jump_addr", jump_addr, 32'd0);
    @(posedge clk);
    #1 oper = 2'd0;
    @(negedge clk);
    chk("eret exl0 status", data_r, 32'd1);
    chk("eret exl0 irout", {31'd0, irout}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
